// File: rtl/hps_pkg.sv
// Shared constants and FSM state encoding for the HPS magnitude store.
package hps_pkg;

    localparam int DEFAULT_K_WIDTH = 11;
    localparam int HALF_LEN        = 2 ** (DEFAULT_K_WIDTH - 1);
    localparam int FRAME_LAST      = 2 ** DEFAULT_K_WIDTH - 1;

    // state    | meaning
    // EMPTY    | nothing stored since reset, waiting for first bin
    // FILL     | writing lower-half bins into RAM
    // DRAIN    | discarding mirrored upper-half bins
    // HOLD     | frame resident, waiting for reader to release it
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic int half_len(input int k);
        return 2 ** (k - 1);
    endfunction

    function automatic int frame_last(input int k);
        return 2 ** k - 1;
    endfunction

endpackage

// File: rtl/hps_mag_store.sv
// Stores the lower half of each magnitude frame into RAM and flags the
// frame as resident until the HPS reader releases it.
module hps_mag_store
    import hps_pkg::*;
#(
    parameter int K_WIDTH    = DEFAULT_K_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  hps_busy,
    output logic                  ram_we,
    output logic [K_WIDTH-2:0]    ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  done_storing_mag,
    output logic                  frame_error,
    output logic [7:0]            frame_count
);

    localparam int A_W = K_WIDTH - 1;
    localparam logic [K_WIDTH-1:0] HALF_LAST_IDX = K_WIDTH'(half_len(K_WIDTH) - 1);
    localparam logic [K_WIDTH-1:0] LAST_IDX      = K_WIDTH'(frame_last(K_WIDTH));

    logic [1:0]            state_q, state_d;
    logic [K_WIDTH-1:0]    idx_q, idx_d;
    logic                  we_q, we_d;
    logic [A_W-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic accept;
    logic idx_is_last;
    logic frame_end;

    assign s_axis_tready = (state_q != ST_HOLD) || !hps_busy;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign idx_is_last   = (idx_q == LAST_IDX);
    assign frame_end     = accept && ((state_q == ST_FILL) || (state_q == ST_DRAIN))
                           && (s_axis_tlast || idx_is_last);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (accept) begin
            unique case (state_q)
                ST_EMPTY, ST_HOLD: begin
                    // tlast on a first bin is flagged but does not end the frame
                    we_d    = 1'b1;
                    addr_d  = '0;
                    wdata_d = s_axis_tdata;
                    idx_d   = K_WIDTH'(1);
                    done_d  = 1'b0;
                    err_d   = s_axis_tlast;
                    state_d = ST_FILL;
                end
                ST_FILL: begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[A_W-1:0];
                    wdata_d = s_axis_tdata;
                    if (!frame_end) begin
                        idx_d = idx_q + K_WIDTH'(1);
                        if (idx_q == HALF_LAST_IDX) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!frame_end) begin
                        idx_d = idx_q + K_WIDTH'(1);
                    end
                end
            endcase
        end

        if (frame_end) begin
            idx_d   = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            err_d   = s_axis_tlast != idx_is_last;
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ram_we           = we_q;
    assign ram_addr         = addr_q;
    assign ram_wdata        = wdata_q;
    assign done_storing_mag = done_q;
    assign frame_error      = err_q;
    assign frame_count      = cnt_q;

endmodule

// File: tb/tb_hps_mag_store.sv
// Randomized bench for hps_mag_store against a frame-position reference model.
module tb_hps_mag_store;

    localparam int K_WIDTH    = 11;
    localparam int DATA_WIDTH = 32;
    localparam int FRAME_LEN  = 2 ** K_WIDTH;
    localparam int HALF       = 2 ** (K_WIDTH - 1);

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [DATA_WIDTH-1:0] s_axis_tdata = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tlast = 1'b0;
    logic                  s_axis_tready;
    logic                  hps_busy = 1'b0;
    logic                  ram_we;
    logic [K_WIDTH-2:0]    ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  done_storing_mag;
    logic                  frame_error;
    logic [7:0]            frame_count;

    hps_mag_store #(.K_WIDTH(K_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .hps_busy         (hps_busy),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .done_storing_mag (done_storing_mag),
        .frame_error      (frame_error),
        .frame_count      (frame_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the next bin within the current frame.
    int   m_pos  = 0;
    bit   m_done = 1'b0;
    int   m_cnt  = 0;
    bit   e_we, e_err;
    int   e_addr;
    logic [31:0] e_wdata;
    bit   last_acc;
    bit   busy_rand = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("ram_we", {31'd0, ram_we}, {31'd0, e_we});
        if (e_we) begin
            check_val("ram_addr", {22'd0, ram_addr}, e_addr);
            check_val("ram_wdata", ram_wdata, e_wdata);
        end
        check_val("done", {31'd0, done_storing_mag}, {31'd0, m_done});
        check_val("frame_error", {31'd0, frame_error}, {31'd0, e_err});
        check_val("frame_count", {24'd0, frame_count}, m_cnt);
    endtask

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic step();
        bit exp_rdy, first, lastp;
        #1;
        exp_rdy = !(m_done && hps_busy);
        check_val("tready", {31'd0, s_axis_tready}, {31'd0, exp_rdy});
        last_acc = s_axis_tvalid && exp_rdy;
        e_we  = 1'b0;
        e_err = 1'b0;
        if (last_acc) begin
            first = (m_pos == 0);
            lastp = (m_pos == FRAME_LEN - 1);
            if (m_pos < HALF) begin
                e_we    = 1'b1;
                e_addr  = m_pos;
                e_wdata = s_axis_tdata;
            end
            if (first) begin
                e_err  = s_axis_tlast;
                m_done = 1'b0;
                m_pos  = 1;
            end else if (s_axis_tlast || lastp) begin
                e_err  = (s_axis_tlast != lastp);
                m_done = 1'b1;
                m_cnt  = (m_cnt + 1) % 256;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        m_pos = 0; m_done = 1'b0; m_cnt = 0; e_we = 1'b0; e_err = 1'b0;
        check_val("rst_we", {31'd0, ram_we}, 32'd0);
        check_val("rst_addr", {22'd0, ram_addr}, 32'd0);
        check_val("rst_wdata", ram_wdata, 32'd0);
        check_val("rst_done", {31'd0, done_storing_mag}, 32'd0);
        check_val("rst_err", {31'd0, frame_error}, 32'd0);
        check_val("rst_count", {24'd0, frame_count}, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic send_frame(input int first_b, input int nbeats, input int tlast_at,
                              input bit idx_data, input int gap_pct);
        int tries, gaps;
        for (int b = first_b; b < nbeats; b++) begin
            gaps = 0;
            while (($urandom_range(0, 99) < gap_pct) && (gaps < 20)) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = $urandom;
                s_axis_tlast  = $urandom_range(0, 1) == 1;
                if (busy_rand) hps_busy = $urandom_range(0, 3) == 0;
                step();
                gaps++;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = idx_data ? 32'(b) : $urandom;
            s_axis_tlast  = (b == tlast_at);
            tries = 0;
            do begin
                if (busy_rand) hps_busy = $urandom_range(0, 3) == 0;
                step();
                tries++;
            end while (!last_acc && tries < 200);
            if (!last_acc) check_val("accept_timeout", 32'd0, 32'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        hps_busy      = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        do_reset();
        step();

        // Clean full frame with tdata = bin index
        send_frame(0, FRAME_LEN, FRAME_LEN - 1, 1'b1, 0);
        repeat (3) step();
        check_val("count_frame1", {24'd0, frame_count}, 32'd1);

        // Reader busy: stalled beat must not be taken
        hps_busy      = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd0;
        s_axis_tlast  = 1'b0;
        repeat (50) step();
        hps_busy = 1'b0;
        step();
        check_val("busy_release_accept", {31'd0, last_acc}, 32'd1);
        send_frame(1, FRAME_LEN, FRAME_LEN - 1, 1'b1, 30);
        repeat (2) step();

        // Early tlast, random gaps and busy noise outside HOLD
        busy_rand = 1'b1;
        send_frame(0, 1500, 1499, 1'b0, 10);
        busy_rand = 1'b0;
        repeat (2) step();

        // Missing tlast
        send_frame(0, FRAME_LEN, -1, 1'b0, 5);
        repeat (2) step();

        // tlast on first beat, then missing at the end
        send_frame(0, FRAME_LEN, 0, 1'b0, 5);
        repeat (2) step();

        // Reset mid-frame then a clean frame
        send_frame(0, 600, -1, 1'b0, 5);
        do_reset();
        step();
        send_frame(0, FRAME_LEN, FRAME_LEN - 1, 1'b1, 10);
        repeat (2) step();
        check_val("count_after_reset", {24'd0, frame_count}, 32'd1);
        check_val("done_after_reset", {31'd0, done_storing_mag}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
